// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared encodings for the multiply/divide unit.
//            - op encodings seen on the op bus
//            - FSM state encodings
//            - counter width helper
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

  // op bus encodings (3'b11x is reserved and ignored)
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // FSM states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Iteration counter must hold the value W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Purpose  : One combinational restoring-divide iteration. The next dividend
//            bit is taken from the MSB of the quotient register, which holds
//            the not-yet-consumed dividend bits and collects quotient bits
//            from the bottom.
// Ports    : i_rem  current partial remainder
//            i_quo  quotient/dividend shift register
//            i_div  divisor magnitude
//            o_rem  next partial remainder
//            o_quo  next quotient/dividend shift register
// Revision : 1.0  initial release
// ============================================================================
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);
  import mdu_pkg::*;

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[W-1]};
    w_diff  = w_shift - {1'b0, i_div};
    // The partial remainder is always below the divisor, so the difference
    // wraps into bit W exactly when the trial subtraction underflows.
    if (!w_diff[W]) begin
      o_rem = w_diff[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b1};
    end else begin
      o_rem = w_shift[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative multiply/divide unit producing the HI/LO pair.
//            MULT/MULTU/DIV/DIVU run one bit per cycle on operand magnitudes,
//            with the sign applied in a final FIX cycle. MTHI/MTLO write
//            hi/lo directly from SrcA while idle.
// Ports    : clk    rising-edge clock
//            rst_n  asynchronous active-low reset
//            start  request, sampled only in IDLE
//            op     operation select (see mdu_pkg)
//            SrcA   operand A / dividend / MTHI-MTLO source
//            SrcB   operand B / divisor
//            busy   operation in flight
//            done   one-cycle pulse when hi/lo take a mult/div result
//            hi     HI register
//            lo     LO register
// Options  : MDU_FAST_MUL_EN - multiplies complete combinationally at accept
//            and go straight to DONE; divide is unaffected.
// Revision : 1.0  initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int c_cnt_w = cnt_width(W);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [W-1:0]       r_rem;     // multiply: product upper half; divide: remainder
  logic [W-1:0]       r_quo;     // multiply: multiplier/product lower half; divide: dividend/quotient
  logic [W-1:0]       r_b;       // multiplicand / divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;   // negate product or quotient
  logic               r_neg_r;   // remainder takes dividend sign
  logic               r_div0;
  logic [W-1:0]       r_hi;
  logic [W-1:0]       r_lo;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic [W-1:0]       w_mag_a;
  logic [W-1:0]       w_mag_b;
  logic [W:0]         w_mul_sum;
  logic [W-1:0]       w_div_rem;
  logic [W-1:0]       w_div_quo;
  logic [2*W-1:0]     w_prod;
  logic [2*W-1:0]     w_prod_s;
  logic [W-1:0]       w_fin_hi;
  logic [W-1:0]       w_fin_lo;

  // --------------------------------------------------------------------------
  // Operand decode at accept
  // --------------------------------------------------------------------------
  always_comb begin
    w_is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_sa     = w_signed & SrcA[W-1];
    w_sb     = w_signed & SrcB[W-1];
    // The most-negative value maps to itself, which is its correct unsigned magnitude.
    w_mag_a  = w_sa ? -SrcA : SrcA;
    w_mag_b  = w_sb ? -SrcB : SrcB;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] w_ext_a;
  logic [2*W-1:0] w_ext_b;
  logic [2*W-1:0] w_fast_prod;

  // A 2W-bit product of sign/zero-extended operands truncated to 2W bits
  // equals the signed or unsigned full product respectively.
  assign w_ext_a     = {{W{w_sa}}, SrcA};
  assign w_ext_b     = {{W{w_sb}}, SrcB};
  assign w_fast_prod = w_ext_a * w_ext_b;
`endif

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the 2W+1-bit {carry,upper,lower} right.
  assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : {(W+1){1'b0}});

  mdu_div_step #(
    .W (W)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_b),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  // Sign fix-up. With a zero divisor the quotient is forced to all ones and
  // the remainder (dividend magnitude with dividend sign) rebuilds SrcA.
  always_comb begin
    w_prod   = {r_rem, r_quo};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_fin_hi = r_neg_r ? -r_rem : r_rem;
    w_fin_lo = r_neg_q ? -r_quo : r_quo;
    if (!r_is_div) begin
      w_fin_hi = w_prod_s[2*W-1:W];
      w_fin_lo = w_prod_s[W-1:0];
    end else if (r_div0) begin
      w_fin_lo = '1;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && w_is_md) begin
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_b      <= w_mag_b;
            r_cnt    <= c_cnt_w'(W);
            r_is_div <= w_is_div;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_div0   <= w_is_div && (SrcB == '0);
`ifdef MDU_FAST_MUL_EN
            if (!w_is_div) begin
              r_hi    <= w_fast_prod[2*W-1:W];
              r_lo    <= w_fast_prod[W-1:0];
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
`else
            r_state  <= S_RUN;
`endif
          end else if (start && (op == OP_MTHI)) begin
            r_hi <= SrcA;
          end else if (start && (op == OP_MTLO)) begin
            r_lo <= SrcA;
          end
        end
        S_RUN: begin
          if (r_is_div) begin
            r_rem <= w_div_rem;
            r_quo <= w_div_quo;
          end else begin
            r_rem <= w_mul_sum[W:1];
            r_quo <= {w_mul_sum[0], r_quo[W-1:1]};
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cnt_w'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_hi    <= w_fin_hi;
          r_lo    <= w_fin_lo;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
